noc_async_fifo_wr: RTL and testbench
====================================

# noc_async_fifo_wr

Write-side endpoint of the NoC asynchronous FIFO link: owns the FIFO storage, accepts packets from a local valid/ready source, and drives a packet/Gray-pointer triple (`data`, `waddr` out; `raddr` in) that the reader in the other clock domain consumes. It is the producer-side counterpart of every `noc_fifo_*_in_data_i / raddr_o / waddr_i` reader port. It is instantiated on the NoC side for the ingress path of a domain, and inside a domain for its `noc_fifo_*_out` path.

## Interface

- `PACKET_SIZE`, default `NOC_ASYNC_FIFO_PACKET_SIZE`: packet width in bits.
- `AWIDTH`, default `NOC_ASYNC_FIFO_AWIDTH`: storage address width; depth `DEPTH = 2**AWIDTH`; pointers are `AWIDTH+1` bits.

- `clk_i`  in  1  write-domain clock.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `in_data_i`  in  PACKET_SIZE  packet to enqueue.
- `in_valid_i`  in  1  `in_data_i` valid.
- `in_ready_o`  out  1  FIFO not full; a write occurs on `in_valid_i & in_ready_o`.
- `level_o`  out  AWIDTH+1  entries outstanding as seen in the write domain, 0..DEPTH.
- `noc_fifo_data_o`  out  PACKET_SIZE  storage word addressed by `noc_fifo_raddr_i`.
- `noc_fifo_raddr_i`  in  AWIDTH+1  reader's Gray-coded read pointer (asynchronous).
- `noc_fifo_waddr_o`  out  AWIDTH+1  Gray-coded write pointer, registered.

## Operation

- Storage: `DEPTH` × `PACKET_SIZE` register array, not reset.
- Write pointer `wptr_bin` (AWIDTH+1 bits) increments modulo 2^(AWIDTH+1) on each accepted write. The word is stored at `wptr_bin[AWIDTH-1:0]`.
- `noc_fifo_waddr_o` = registered `wptr_bin ^ (wptr_bin >> 1)`, updated on the same edge as the storage write. It is the sole flop driving the port: no combinational logic after the register.
- `noc_fifo_data_o` = `mem[gray2bin(noc_fifo_raddr_i)[AWIDTH-1:0]]`, combinational from the raw port. The reader only addresses slots it has seen committed via `waddr`, so the word is stable when sampled.
- `noc_fifo_raddr_i` is passed through an N-flop synchronizer (N=2, see Configuration) to give `rptr_sync_gray`. It is converted to binary `rptr_sync_bin`.
- Full: `wptr_gray == {~rptr_sync_gray[AWIDTH:AWIDTH-1], rptr_sync_gray[AWIDTH-2:0]}`. For AWIDTH=1 the full condition inverts both bits.
- `in_ready_o = ~full`, derived from registers only. A write attempted while full is ignored: no state change, and data is not corrupted.
- `level_o = wptr_bin - rptr_sync_bin` (mod 2^(AWIDTH+1)). It is conservative: it over-reports by the synchronizer lag and never under-reports.
- No state machine beyond pointers; no backpressure toward the reader.

## Timing

- Reset (async assert, sync-released externally): `wptr_bin=0`, `noc_fifo_waddr_o=0`, synchronizer flops 0, `in_ready_o=1`, `level_o=0`. `noc_fifo_data_o` is undefined until a slot is written.
- Write at edge k:
  - `noc_fifo_waddr_o` and `level_o` reflect it after edge k.
  - If the write fills the FIFO, `in_ready_o` is 0 after edge k.
- A reader pointer change is visible to `full`/`level_o` after N `clk_i` edges.
- A simultaneous write and read-pointer change are both applied: `level_o` changes by +1 now and by −1 N cycles later.
- Wrap-around: the pointer MSB toggles every DEPTH writes; Gray sequence for AWIDTH=2 is 000,001,011,010,110,111,101,100,000.
- Reset mid-operation discards all contents. The writer and reader sides must be reset together; a one-sided reset is unsupported.

## Configuration

- `NOC_ASYNC_FIFO_SYNC3_EN`:
  - Defined: the read-pointer synchronizer has 3 flops (N=3) for high-frequency/MTBF-critical crossings.
  - Undefined: 2 flops (N=2).
  - No other behaviour differs.

## Test plan

Bench parameters: AWIDTH=2, PACKET_SIZE=8, macro undefined unless stated.

- Reset check: assert `reset_n_i`=0 → `noc_fifo_waddr_o`=0, `in_ready_o`=1, `level_o`=0, immediately and without a clock edge.
- Fill: `raddr`=0; write 0xA0..0xA3 back-to-back → `waddr_o` = 001, 011, 010, 110; `in_ready_o`=0 after the 4th write; `level_o`=4. Hold a 5th valid 0xA4 → not accepted; `waddr_o` stays 110.
- Data path: `raddr`=000 → `data_o`=0xA0; `raddr`=001 → 0xA1; `raddr`=010 → 0xA3, combinationally.
- Drain lag: while full, set `raddr`=001 → `in_ready_o` rises exactly 2 edges later (3 with `NOC_ASYNC_FIFO_SYNC3_EN`); `level_o`=3.
- Wrap: 12 writes of 0x00..0x0B with the reader model following → `waddr_o` passes 100 → 000; every packet is read back in order; `level_o` never exceeds 4.
- Mid-burst reset: assert `reset_n_i` during a write burst → all outputs return to reset values asynchronously; after release, the first write lands in slot 0.

Source files
------------

// File: rtl/noc_async_fifo_wr.sv
// noc_async_fifo_wr: write-side endpoint of the NoC async FIFO link.
// Option macro NOC_ASYNC_FIFO_SYNC3_EN: 3-flop read-pointer sync.

package noc_async_fifo_pkg;
    parameter int NOC_ASYNC_FIFO_PACKET_SIZE = 32;
    parameter int NOC_ASYNC_FIFO_AWIDTH      = 4;
endpackage

module noc_async_fifo_wr
    import noc_async_fifo_pkg::*;
#(
    parameter int PACKET_SIZE = NOC_ASYNC_FIFO_PACKET_SIZE,
    parameter int AWIDTH      = NOC_ASYNC_FIFO_AWIDTH
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [PACKET_SIZE-1:0] in_data_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output logic [AWIDTH:0]        level_o,
    output logic [PACKET_SIZE-1:0] noc_fifo_data_o,
    input  logic [AWIDTH:0]        noc_fifo_raddr_i,
    output logic [AWIDTH:0]        noc_fifo_waddr_o
);

    localparam int DEPTH = 2 ** AWIDTH;

`ifdef NOC_ASYNC_FIFO_SYNC3_EN
    localparam int SYNC_N = 3;
`else
    localparam int SYNC_N = 2;
`endif

    // Top two Gray bits differ between write and read pointer when full.
    localparam logic [AWIDTH:0] FULL_MASK = (AWIDTH+1)'(3) << (AWIDTH-1);

    logic [PACKET_SIZE-1:0] mem [DEPTH];

    logic [AWIDTH:0]   wptr_bin;
    logic [AWIDTH:0]   wptr_next;
    logic [AWIDTH:0]   wptr_gray;
    logic [AWIDTH:0]   sync_q [SYNC_N];
    logic [AWIDTH:0]   rptr_sync_gray;
    logic [AWIDTH:0]   rptr_sync_bin;
    logic [AWIDTH-1:0] rd_idx;
    logic              full;
    logic              wr_en;

    function automatic logic [AWIDTH:0] gray2bin(input logic [AWIDTH:0] g);
        logic [AWIDTH:0] b;
        b[AWIDTH] = g[AWIDTH];
        for (int i = AWIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign wptr_next      = wptr_bin + (AWIDTH+1)'(1);
    assign rptr_sync_gray = sync_q[SYNC_N-1];
    assign rptr_sync_bin  = gray2bin(rptr_sync_gray);

    // Full and level come from registers only, so ready has no input path.
    assign full       = (wptr_gray == (rptr_sync_gray ^ FULL_MASK));
    assign in_ready_o = ~full;
    assign wr_en      = in_valid_i & ~full;
    assign level_o    = wptr_bin - rptr_sync_bin;

    assign noc_fifo_waddr_o = wptr_gray;

    // Binary pointer and its registered Gray image advance together.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_bin  <= '0;
            wptr_gray <= '0;
        end else if (wr_en) begin
            wptr_bin  <= wptr_next;
            wptr_gray <= wptr_next ^ (wptr_next >> 1);
        end
    end

    // Storage is not reset; the reader only reads committed slots.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wptr_bin[AWIDTH-1:0]] <= in_data_i;
        end
    end

    // Synchronizer chain for the reader's Gray pointer.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < SYNC_N; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= noc_fifo_raddr_i;
            for (int i = 1; i < SYNC_N; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Raw read pointer to slot index: bit i is the XOR of Gray bits >= i.
    always_comb begin
        rd_idx = '0;
        for (int i = 0; i < AWIDTH; i++) begin
            rd_idx[i] = ^(noc_fifo_raddr_i >> i);
        end
    end

    assign noc_fifo_data_o = mem[rd_idx];

endmodule

// File: tb/tb_noc_async_fifo_wr.sv
// tb_noc_async_fifo_wr: directed bench for noc_async_fifo_wr.
// Runs with AWIDTH=2, PACKET_SIZE=8.

module tb_noc_async_fifo_wr;

`ifdef NOC_ASYNC_FIFO_SYNC3_EN
    localparam int N = 3;
`else
    localparam int N = 2;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] level;
    logic [7:0] fifo_data;
    logic [2:0] fifo_raddr;
    logic [2:0] fifo_waddr;

    int n_chk  = 0;
    int n_pass = 0;

    logic [2:0] gray_tbl [8] = '{3'b001, 3'b011, 3'b010, 3'b110,
                                 3'b111, 3'b101, 3'b100, 3'b000};

    noc_async_fifo_wr #(
        .PACKET_SIZE(8),
        .AWIDTH     (2)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .in_data_i       (in_data),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .level_o         (level),
        .noc_fifo_data_o (fifo_data),
        .noc_fifo_raddr_i(fifo_raddr),
        .noc_fifo_waddr_o(fifo_waddr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        fifo_raddr = 3'b000;
        #2;
        chk("rst_waddr", 32'(fifo_waddr), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_level", 32'(level), 0);
        tick();
        reset_n = 1'b1;

        // fill
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'hA0 + 8'(i);
            tick();
            chk("fill_waddr", 32'(fifo_waddr), 32'(gray_tbl[i]));
        end
        chk("full_ready", 32'(in_ready), 0);
        chk("full_level", 32'(level), 4);
        in_data = 8'hA4;
        tick();
        chk("ovf_waddr", 32'(fifo_waddr), 32'b110);
        chk("ovf_level", 32'(level), 4);
        chk("ovf_ready", 32'(in_ready), 0);
        in_valid = 1'b0;

        // combinational data path
        fifo_raddr = 3'b000; #1;
        chk("data_000", 32'(fifo_data), 32'hA0);
        fifo_raddr = 3'b001; #1;
        chk("data_001", 32'(fifo_data), 32'hA1);
        fifo_raddr = 3'b011; #1;
        chk("data_011", 32'(fifo_data), 32'hA2);
        fifo_raddr = 3'b010; #1;
        chk("data_010", 32'(fifo_data), 32'hA3);

        // drain lag
        fifo_raddr = 3'b001;
        for (int k = 1; k <= N; k++) begin
            tick();
            chk("lag_ready", 32'(in_ready), (k == N) ? 1 : 0);
            chk("lag_level", 32'(level), (k == N) ? 3 : 4);
        end

        // clean restart for wrap test
        reset_n = 1'b0;
        #1;
        fifo_raddr = 3'b000;
        reset_n = 1'b1;

        // wrap with reader following
        in_valid = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            in_data = 8'(k - 1);
            tick();
            chk("wrap_waddr", 32'(fifo_waddr), 32'(gray_tbl[(k-1)%8]));
            chk("wrap_data", 32'(fifo_data), 32'(k - 1));
            chk("wrap_lvl_le4", 32'(level <= 3'd4), 1);
            chk("wrap_ready", 32'(in_ready), 1);
            fifo_raddr = gray_tbl[(k-1)%8];
        end
        in_valid = 1'b0;

        // mid-burst reset
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick();
        in_data  = 8'h78;
        tick();
        #3;
        reset_n    = 1'b0;
        fifo_raddr = 3'b000;
        #1;
        chk("mrst_waddr", 32'(fifo_waddr), 0);
        chk("mrst_ready", 32'(in_ready), 1);
        chk("mrst_level", 32'(level), 0);
        in_valid = 1'b0;
        tick();
        reset_n  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h5C;
        tick();
        in_valid = 1'b0;
        chk("post_waddr", 32'(fifo_waddr), 32'b001);
        chk("post_data0", 32'(fifo_data), 32'h5C);
        chk("post_level", 32'(level), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
